// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcodes and response-stage states.
package alu_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_NOT = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_LT  = 3'b110;
  localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic             id;
    logic [ALU_W-1:0] data;
  } rsp_payload_t;

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU with zero and signed-overflow flags.
module alu4
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [ALU_W-1:0] result,
  output logic             zero,
  output logic             ovf
);

  logic [ALU_W-1:0] sum;
  logic [ALU_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a + (~b) + ALU_W'(1);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf    = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
      end
      OP_NOT: result = ~a;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      // Raw sign of the difference, deliberately without overflow correction
      OP_LT:  result = {{(ALU_W-1){1'b0}}, diff[ALU_W-1]};
      OP_EQ:  result = {{(ALU_W-1){1'b0}}, (diff == '0)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared alu4 with a single-entry
// response register. Define ALU_ARB_FLAGS_EN to expose rsp_zero/rsp_ovf.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [ALU_W-1:0] req0_a,
  input  logic [ALU_W-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [ALU_W-1:0] req1_a,
  input  logic [ALU_W-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [ALU_W-1:0] rsp_data
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_ovf
`endif
);

  rsp_state_e   state_q, state_d;
  rsp_payload_t rsp_q, rsp_d;
  logic         prio_q, prio_d;

  logic             grant0, grant1;
  logic             stage_free;
  logic             accept;
  logic [OP_W-1:0]  alu_op;
  logic [ALU_W-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero, alu_ovf;

  // Grant depends only on valids and the pointer, never on payload
  assign grant0     = req0_valid && (!req1_valid || !prio_q);
  assign grant1     = req1_valid && (!req0_valid ||  prio_q);
  assign stage_free = (state_q == RSP_EMPTY) || rsp_ready;
  assign req0_ready = grant0 && stage_free && rst_n;
  assign req1_ready = grant1 && stage_free && rst_n;
  assign accept     = req0_ready || req1_ready;

  assign alu_op = grant1 ? req1_op : req0_op;
  assign alu_a  = grant1 ? req1_a  : req0_a;
  assign alu_b  = grant1 ? req1_b  : req0_b;

  alu4 u_alu4 (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .ovf    (alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    prio_d  = prio_q;
    if (accept) begin
      state_d    = RSP_FULL;
      rsp_d.id   = grant1;
      rsp_d.data = alu_result;
      prio_d     = ~grant1;
    end else if ((state_q == RSP_FULL) && rsp_ready) begin
      state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RSP_EMPTY;
      rsp_q   <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      prio_q  <= prio_d;
    end
  end

  assign rsp_valid = (state_q == RSP_FULL);
  assign rsp_id    = rsp_q.id;
  assign rsp_data  = rsp_q.data;

`ifdef ALU_ARB_FLAGS_EN
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;

  always_comb begin
    zero_d = zero_q;
    ovf_d  = ovf_q;
    if (accept) begin
      zero_d = alu_zero;
      ovf_d  = alu_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign rsp_zero = zero_q;
  assign rsp_ovf  = ovf_q;
`else
  logic unused_flags;
  assign unused_flags = alu_zero ^ alu_ovf;
`endif

endmodule
